// File: rtl/uart_tx_engine_pkg.sv
// Shared definitions for the UART transmit path: widths, frame length, FSM states
// and standard bit-time divisors.
package uart_tx_engine_pkg;

    localparam int unsigned BAUD_W     = 19;
    localparam int unsigned FRAME_BITS = 11;
    localparam int unsigned BIT_CNT_W  = $clog2(FRAME_BITS + 1);

    // Divisors for a 100 MHz clock: k = 100e6 / baud - 1 (one bit lasts k+1 clocks).
    localparam logic [BAUD_W-1:0] K_9600   = 19'd10415;
    localparam logic [BAUD_W-1:0] K_19200  = 19'd5207;
    localparam logic [BAUD_W-1:0] K_38400  = 19'd2603;
    localparam logic [BAUD_W-1:0] K_57600  = 19'd1735;
    localparam logic [BAUD_W-1:0] K_115200 = 19'd867;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StShift
    } tx_state_e;

endpackage

// File: rtl/uart_tx_engine_decode.sv
// Parity/stop-bit decoder: produces the two upper frame bits {bit10, bit9}
// from the data byte and the eight/pen/ohel configuration.
module uart_tx_engine_decode (
    input  logic       eight_i,
    input  logic       pen_i,
    input  logic       ohel_i,
    input  logic [7:0] data_i,
    output logic [1:0] dout_o
);

    always_comb begin
        dout_o = 2'b11;
        unique case ({eight_i, pen_i})
            2'b00: dout_o = 2'b11;
            2'b01: dout_o = {1'b1, ohel_i ? ~^data_i[6:0] : ^data_i[6:0]};
            2'b10: dout_o = {1'b1, data_i[7]};
            2'b11: dout_o = {ohel_i ? ~^data_i : ^data_i, data_i[7]};
        endcase
    end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit engine: latches a byte on load, builds an 11-bit frame and shifts
// it out LSB-first at one bit per k+1 clocks, reporting txrdy when free.
module uart_tx_engine
    import uart_tx_engine_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load_i,
    input  logic [7:0]        out_port_i,
    input  logic              eight_i,
    input  logic              pen_i,
    input  logic              ohel_i,
    input  logic [BAUD_W-1:0] k_i,
    output logic              tx_o,
    output logic              txrdy_o
);

    tx_state_e             state_q;
    logic [7:0]            ldata_q;
    logic [FRAME_BITS-1:0] shift_q;
    logic [BAUD_W-1:0]     bt_cnt_q;
    logic [BIT_CNT_W-1:0]  bit_cnt_q;
    logic                  txrdy_q;
    logic [1:0]            dec;
    logic                  btu;
    logic                  last_bit;

    uart_tx_engine_decode u_decode (
        .eight_i (eight_i),
        .pen_i   (pen_i),
        .ohel_i  (ohel_i),
        .data_i  (ldata_q),
        .dout_o  (dec)
    );

    // Equality compare lets a k lowered mid-frame wrap the counter instead of stalling.
    assign btu      = (state_q == StShift) && (bt_cnt_q == k_i);
    assign last_bit = (bit_cnt_q == BIT_CNT_W'(FRAME_BITS - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            ldata_q   <= 8'h00;
            shift_q   <= '1;
            bt_cnt_q  <= '0;
            bit_cnt_q <= '0;
            txrdy_q   <= 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (load_i) begin
                        ldata_q <= out_port_i;
                        txrdy_q <= 1'b0;
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    // Idle bit first, then start bit, data[6:0] and the decoded upper bits.
                    shift_q   <= {dec, ldata_q[6:0], 1'b0, 1'b1};
                    bt_cnt_q  <= '0;
                    bit_cnt_q <= '0;
                    state_q   <= StShift;
                end
                StShift: begin
                    if (btu) begin
                        bt_cnt_q  <= '0;
                        shift_q   <= {1'b1, shift_q[FRAME_BITS-1:1]};
                        bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(1);
                        if (last_bit) begin
                            bit_cnt_q <= '0;
                            txrdy_q   <= 1'b1;
                            state_q   <= StIdle;
                        end
                    end else begin
                        bt_cnt_q <= bt_cnt_q + BAUD_W'(1);
                    end
                end
                default: begin
                    shift_q <= '1;
                    txrdy_q <= 1'b1;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign tx_o    = shift_q[0];
    assign txrdy_o = txrdy_q;

endmodule
